bictr_dcnto_checker: RTL

Self-checking monitor at the receiving end of the DW03_bictr_dcnto stimulus path. It samples the same load/cen/up_dn/data/count_to that drive the counter DUT and runs its own cycle-accurate reference model of the counter. Every cycle it compares the model against the DUT's count and tercnt, and reports mismatches, an error tally and the first failing cycle. It is synthesizable and sits beside the DUT in the counter testbench and in the FPGA smoke build.

---
 rtl/bictr_dcnto_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/bictr_dcnto_checker.sv
// Reference model and scoreboard for the DW03_bictr_dcnto up/down counter.
// The model tracks the DUT edge-for-edge. Mismatches are tallied while the checker is in RUN.
module bictr_dcnto_checker #(
   parameter int WIDTH       = 8,
   parameter int ERRW        = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             check_en,
   input  logic             load,
   input  logic             cen,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] count_to,
   input  logic [WIDTH-1:0] dut_count,
   input  logic             dut_tercnt,
   output logic [WIDTH-1:0] exp_count,
   output logic             err,
   output logic [ERRW-1:0]  err_count,
   output logic [ERRW-1:0]  first_err_cyc,
   output logic             halted,
   output logic             pass
);

   typedef enum logic [1:0] {IDLE, SYNC, RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] expCount_q, expCount_d;
   logic [ERRW-1:0]  errCount_q, errCount_d;
   logic [ERRW-1:0]  firstErr_q, firstErr_d;
   logic [ERRW-1:0]  cyc_q, cyc_d;
   logic             err_q, err_d;
   logic             pass_q, pass_d;
   logic             expTercnt;
   logic             mismatch;
   logic             compareEn;

   // Case-inequality makes X/Z on the DUT outputs count as a mismatch in simulation.
   assign expTercnt = (expCount_q == count_to);
   assign mismatch  = (dut_count !== expCount_q) || (dut_tercnt !== expTercnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (check_en) state_d = SYNC;
         SYNC: state_d = check_en ? RUN : IDLE;
         RUN: begin
            if (STOP_ON_ERR && mismatch) state_d = HALT;
            else if (!check_en)          state_d = IDLE;
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      compareEn = (state_q == RUN);
      halted    = (state_q == HALT);
   end

   // The model runs in every state, so it is already aligned with the DUT when RUN starts.
   always_comb begin
      expCount_d = expCount_q;
      if (!load)     expCount_d = data;
      else if (cen)  expCount_d = up_dn ? expCount_q + WIDTH'(1) : expCount_q - WIDTH'(1);
   end

   always_comb begin
      errCount_d = errCount_q;
      firstErr_d = firstErr_q;
      cyc_d      = cyc_q;
      err_d      = 1'b0;
      if (compareEn) begin
         if (!(&cyc_q)) cyc_d = cyc_q + ERRW'(1);
         if (mismatch) begin
            err_d = 1'b1;
            if (!(&errCount_q))       errCount_d = errCount_q + ERRW'(1);
            if (errCount_q == '0)     firstErr_d = cyc_q;
         end
      end
      pass_d = (state_d == RUN) && (errCount_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         expCount_q <= '0;
         errCount_q <= '0;
         firstErr_q <= '0;
         cyc_q      <= '0;
         err_q      <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         expCount_q <= expCount_d;
         errCount_q <= errCount_d;
         firstErr_q <= firstErr_d;
         cyc_q      <= cyc_d;
         err_q      <= err_d;
         pass_q     <= pass_d;
      end
   end

   assign exp_count     = expCount_q;
   assign err           = err_q;
   assign err_count     = errCount_q;
   assign first_err_cyc = firstErr_q;
   assign pass          = pass_q;

endmodule
